counter_trig_ctrl: RTL and testbench
====================================

COUNTER_TRIG_CTRL -- requirements
Module: counter_trig_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: counter width in bits; legal range 8..32.
REQ-002 Parameter HOLD_W, default 16: holdoff counter width in bits.
REQ-003 Port clk1  input  1: single clock, sourced from the on-chip oscillator; all logic is on its rising edge.
REQ-004 Port rstn  input  1: reset, asynchronous and active-low; this polarity and synchronicity are fixed.
REQ-005 Port cmd_start  input  1: one-cycle request to begin counting.
REQ-006 Port cmd_stop  input  1: one-cycle request to halt counting.
REQ-007 Port cmd_clear  input  1: one-cycle request to zero the counter.
REQ-008 Port cmp_val  input  CNT_W: trigger compare value, sampled every cycle.
REQ-009 Port holdoff_len  input  HOLD_W: post-trigger holdoff length, sampled on the trigger cycle.
REQ-010 Port cnt  output  CNT_W: current counter value.
REQ-011 Port running  output  1: high in states RUN and HOLDOFF.
REQ-012 Port trig_pulse  output  1: one-cycle trigger strobe, intended as the Reveal trigger source.
REQ-013 Port trig_count  output  8: number of triggers since the last reset or clear; saturates.
REQ-014 Port led  output  4: status LEDs, equal to cnt[CNT_W-1:CNT_W-4].

Function
REQ-015 The controller SHALL implement an FSM with states IDLE, RUN and HOLDOFF; all outputs are registered.
REQ-016 In IDLE, cnt SHALL hold its value.
REQ-017 In RUN and HOLDOFF, cnt SHALL increment by 1 per cycle and wrap from all-ones to 0 without any other effect.
REQ-018 Command priority SHALL be cmd_clear > cmd_stop > cmd_start, and also above a compare match in the same cycle.
REQ-019 cmd_clear SHALL, in any state, set cnt to 0 and trig_count to 0 on the next edge, leave the state unchanged, and suppress a match in that cycle.
REQ-020 cmd_stop SHALL move RUN or HOLDOFF to IDLE on the next edge; cmd_stop in IDLE SHALL have no effect.
REQ-021 cmd_start SHALL move IDLE to RUN; cnt increments from the first RUN cycle; cmd_start in RUN or HOLDOFF SHALL be ignored.
REQ-022 A match (state RUN and cnt == cmp_val at a rising edge) SHALL, on that edge:
  - set trig_pulse to 1 for exactly one cycle;
  - increment trig_count, saturating at 255;
  - load the holdoff counter with holdoff_len;
  - move the state to HOLDOFF.
REQ-023 In HOLDOFF, the FSM SHALL return to RUN when the holdoff counter is 0 and otherwise decrement it; HOLDOFF therefore lasts holdoff_len+1 cycles, and holdoff_len=0 gives 1 cycle.
REQ-024 Compare matches in IDLE or HOLDOFF SHALL be ignored.
REQ-025 A cmp_val reached via wrap-around SHALL trigger normally.
REQ-026 Changes to cmp_val SHALL take effect on the next compare; changes to holdoff_len during HOLDOFF SHALL be ignored.

Reset
REQ-027 While rstn=0, regardless of clk1: state=IDLE, cnt=0, trig_pulse=0, trig_count=0, holdoff counter=0, running=0, led=0.
REQ-028 Reset assertion mid-RUN or mid-HOLDOFF SHALL abort immediately, with no trigger pulse emitted.
REQ-029 The first active edge after rstn rises SHALL see state IDLE; the rstn deassertion path SHALL be synchronised externally.

Structure
REQ-030 The FSM state encoding and the constants TRIG_CNT_MAX=255 and LED_W=4 SHALL live in the shared package counter_pkg.
REQ-031 The counter, comparator and FSM SHALL be implemented in one module; the free-running counter SHALL be a sub-module named counter_core with inputs en and clr and output cnt.
REQ-032 The block SHALL contain no oscillator primitive; clk1 is supplied by the top level.

Verification
REQ-033 The bench SHALL cover, with CNT_W=32:
  - Reset, then cmd_start, run 10 cycles -> cnt=10, running=1, led=0.
  - cmp_val=5, holdoff_len=3, start -> trig_pulse high one cycle after cnt==5; running stays 1; after 4 HOLDOFF cycles state=RUN; trig_count=1.
  - Preload by running to cnt=0xFFFFFFFE with cmp_val=0x00000001 -> wrap to 0, trigger at cnt==1, trig_count increments.
  - cmd_clear and match in the same cycle (cmp_val=7, clear at cnt==7) -> cnt=0, no trig_pulse, trig_count=0.
  - cmp_val=0, holdoff_len=0, 300 wraps simulated with CNT_W=8 -> trig_count saturates at 255, with trig_pulse still pulsing on every match.
  - rstn low during HOLDOFF -> all outputs 0 immediately and asynchronously; cmd_stop during HOLDOFF -> IDLE with cnt frozen.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared state encoding and constants for the trigger controller.
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   localparam int TRIG_CNT_MAX = 255;
   localparam int LED_W        = 4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'(TRIG_CNT_MAX)) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/counter_core.sv
// Free-running wrap-around counter; clear wins over enable.
module counter_core #(
   parameter int CNT_W = 32
) (
   input  logic             clk1,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/counter_trig_ctrl.sv
// Counter with compare trigger, post-trigger holdoff and saturating trigger count.
module counter_trig_ctrl
   import counter_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int HOLD_W = 16
) (
   input  logic              clk1,
   input  logic              rstn,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic              cmd_clear,
   input  logic [CNT_W-1:0]  cmp_val,
   input  logic [HOLD_W-1:0] holdoff_len,
   output logic [CNT_W-1:0]  cnt,
   output logic              running,
   output logic              trig_pulse,
   output logic [7:0]        trig_count,
   output logic [LED_W-1:0]  led
);

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              trig_pulse_q, trig_pulse_d;
   logic [7:0]        trig_count_q, trig_count_d;
   logic              running_q, running_d;
   logic              cnt_en, match;

   counter_core #(.CNT_W(CNT_W)) u_core (
      .clk1 (clk1),
      .rstn (rstn),
      .en   (cnt_en),
      .clr  (cmd_clear),
      .cnt  (cnt)
   );

   // The counter advances in every non-IDLE cycle, including the one where stop lands.
   assign cnt_en = (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      trig_pulse_d = 1'b0;
      trig_count_d = trig_count_q;
      match        = 1'b0;

      if (cmd_clear) begin
         trig_count_d = '0;
      end else if (cmd_stop) begin
         if (state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end
      end else begin
         case (state_q)
            ST_IDLE:    if (cmd_start) state_d = ST_RUN;
            ST_RUN:     match = (cnt == cmp_val);
            ST_HOLDOFF: begin
               if (hold_q == '0) state_d = ST_RUN;
               else              hold_d  = hold_q - HOLD_W'(1);
            end
            default:    state_d = ST_IDLE;
         endcase
      end

      if (match) begin
         trig_pulse_d = 1'b1;
         trig_count_d = sat_inc8(trig_count_q);
         hold_d       = holdoff_len;
         state_d      = ST_HOLDOFF;
      end

      running_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         trig_pulse_q <= 1'b0;
         trig_count_q <= '0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         trig_pulse_q <= trig_pulse_d;
         trig_count_q <= trig_count_d;
         running_q    <= running_d;
      end
   end

   assign running    = running_q;
   assign trig_pulse = trig_pulse_q;
   assign trig_count = trig_count_q;
   assign led        = cnt[CNT_W-1 -: LED_W];

endmodule

// File: tb/tb_counter_trig_ctrl.sv
// Scoreboard bench: a 32-bit instance for the main scenarios, an 8-bit one for wrap and saturation.
module tb_counter_trig_ctrl;

   logic        clk1 = 1'b0;
   logic        rstn = 1'b0;
   always #5 clk1 = ~clk1;

   logic        a_start, a_stop, a_clear;
   logic [31:0] a_cmp;
   logic [15:0] a_hold;
   logic [31:0] a_cnt;
   logic        a_running, a_pulse;
   logic [7:0]  a_tc;
   logic [3:0]  a_led;

   logic        b_start, b_stop, b_clear;
   logic [7:0]  b_cmp;
   logic [15:0] b_hold;
   logic [7:0]  b_cnt;
   logic        b_running, b_pulse;
   logic [7:0]  b_tc;
   logic [3:0]  b_led;

   counter_trig_ctrl #(.CNT_W(32), .HOLD_W(16)) dut_a (
      .clk1(clk1), .rstn(rstn), .cmd_start(a_start), .cmd_stop(a_stop),
      .cmd_clear(a_clear), .cmp_val(a_cmp), .holdoff_len(a_hold),
      .cnt(a_cnt), .running(a_running), .trig_pulse(a_pulse),
      .trig_count(a_tc), .led(a_led)
   );

   counter_trig_ctrl #(.CNT_W(8), .HOLD_W(16)) dut_b (
      .clk1(clk1), .rstn(rstn), .cmd_start(b_start), .cmd_stop(b_stop),
      .cmd_clear(b_clear), .cmp_val(b_cmp), .holdoff_len(b_hold),
      .cnt(b_cnt), .running(b_running), .trig_pulse(b_pulse),
      .trig_count(b_tc), .led(b_led)
   );

   typedef struct {
      logic [31:0] cnt;
      logic [7:0]  tc;
   } trig_t;

   typedef struct {
      bit          dut_b;
      logic [31:0] cnt;
      logic        running;
      logic        pulse;
      logic [7:0]  tc;
      logic [3:0]  led;
      string       name;
   } snap_t;

   trig_t a_exp_q[$];
   trig_t b_exp_q[$];
   snap_t snap_q[$];
   logic  snap_req = 1'b0;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Trigger monitors: every pulse must match the next queued expectation.
   always @(negedge clk1) begin
      trig_t t;
      if (a_pulse === 1'b1) begin
         if (a_exp_q.size() == 0) chk("A unexpected trig_pulse", 32'(a_pulse), 32'd0);
         else begin
            t = a_exp_q.pop_front();
            chk("A trig cnt", a_cnt, t.cnt);
            chk("A trig trig_count", 32'(a_tc), 32'(t.tc));
         end
      end
   end

   always @(negedge clk1) begin
      trig_t t;
      if (b_pulse === 1'b1) begin
         if (b_exp_q.size() == 0) chk("B unexpected trig_pulse", 32'(b_pulse), 32'd0);
         else begin
            t = b_exp_q.pop_front();
            chk("B trig cnt", 32'(b_cnt), t.cnt);
            chk("B trig trig_count", 32'(b_tc), 32'(t.tc));
         end
      end
   end

   // Snapshot monitor: compares a full output snapshot whenever the stimulus requests one.
   always @(negedge clk1) begin
      snap_t s;
      if (snap_req) begin
         if (snap_q.size() == 0) chk("snapshot queue", 32'(snap_q.size()), 32'd1);
         else begin
            s = snap_q.pop_front();
            chk({s.name, " cnt"},        s.dut_b ? 32'(b_cnt)     : a_cnt,         s.cnt);
            chk({s.name, " running"},    s.dut_b ? 32'(b_running) : 32'(a_running), 32'(s.running));
            chk({s.name, " trig_pulse"}, s.dut_b ? 32'(b_pulse)   : 32'(a_pulse),   32'(s.pulse));
            chk({s.name, " trig_count"}, s.dut_b ? 32'(b_tc)      : 32'(a_tc),      32'(s.tc));
            chk({s.name, " led"},        s.dut_b ? 32'(b_led)     : 32'(a_led),     32'(s.led));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   task automatic snap(input bit dut_b, input logic [31:0] c, input logic r, input logic p,
                       input logic [7:0] tc, input logic [3:0] led, input string name);
      snap_t s;
      s.dut_b = dut_b; s.cnt = c; s.running = r; s.pulse = p; s.tc = tc; s.led = led; s.name = name;
      snap_q.push_back(s);
      snap_req = 1'b1;
      @(negedge clk1);
      #1 snap_req = 1'b0;
   endtask

   task automatic push_a(input logic [31:0] c, input logic [7:0] tc);
      trig_t t;
      t.cnt = c; t.tc = tc;
      a_exp_q.push_back(t);
   endtask

   task automatic push_b(input logic [31:0] c, input logic [7:0] tc);
      trig_t t;
      t.cnt = c; t.tc = tc;
      b_exp_q.push_back(t);
   endtask

   initial begin
      a_start = 0; a_stop = 0; a_clear = 0; a_cmp = 32'hFFFF_0000; a_hold = 16'd3;
      b_start = 0; b_stop = 0; b_clear = 0; b_cmp = 8'hFF;         b_hold = 16'd0;

      tick(2);
      snap(1'b0, 0, 0, 0, 0, 0, "A reset");
      tick(1);
      snap(1'b1, 0, 0, 0, 0, 0, "B reset");
      rstn = 1'b1;
      tick(1);

      // Start, run ten cycles, then stop and hold
      a_start = 1; tick(1); a_start = 0;
      tick(10);
      snap(1'b0, 10, 1, 0, 0, 0, "A run10");
      a_stop = 1; tick(1); a_stop = 0;
      snap(1'b0, 11, 0, 0, 0, 0, "A stop");
      tick(3);
      snap(1'b0, 11, 0, 0, 0, 0, "A idle hold");

      // Trigger at cnt==5 with holdoff 3; holdoff_len change and a match during HOLDOFF are ignored
      a_clear = 1; tick(1); a_clear = 0;
      snap(1'b0, 0, 0, 0, 0, 0, "A clear idle");
      a_cmp = 5; a_hold = 3;
      a_start = 1; tick(1); a_start = 0;
      push_a(6, 1);
      tick(6);
      snap(1'b0, 6, 1, 1, 1, 0, "A trig5");
      a_hold = 9; a_cmp = 9;
      tick(4);
      a_cmp = 10;
      push_a(11, 2);
      tick(1);
      snap(1'b0, 11, 1, 1, 2, 0, "A retrig after holdoff");
      tick(2);
      a_stop = 1; tick(1); a_stop = 0;
      snap(1'b0, 14, 0, 0, 2, 0, "A stop in holdoff");
      tick(3);
      snap(1'b0, 14, 0, 0, 2, 0, "A frozen");

      // Clear coinciding with a match suppresses it
      a_clear = 1; a_hold = 3; tick(1); a_clear = 0;
      snap(1'b0, 0, 0, 0, 0, 0, "A clear2");
      a_cmp = 7;
      a_start = 1; tick(1); a_start = 0;
      tick(7);
      a_clear = 1; tick(1); a_clear = 0;
      snap(1'b0, 0, 1, 0, 0, 0, "A clear vs match");
      push_a(8, 1);
      tick(8);
      snap(1'b0, 8, 1, 1, 1, 0, "A match after clear");

      // Asynchronous reset in HOLDOFF
      tick(1);
      rstn = 1'b0;
      snap(1'b0, 0, 0, 0, 0, 0, "A async reset holdoff");
      rstn = 1'b1;
      tick(1);

      // Reset right after the match edge must swallow the pulse
      a_cmp = 3;
      a_start = 1; tick(1); a_start = 0;
      tick(4);
      rstn = 1'b0;
      snap(1'b0, 0, 0, 0, 0, 0, "A reset on trig");
      rstn = 1'b1;
      tick(1);

      // 8-bit: run to 0xFE, retarget to 1, wrap and trigger
      b_start = 1; tick(1); b_start = 0;
      tick(254);
      snap(1'b1, 32'hFE, 1, 0, 0, 4'hF, "B preload");
      b_cmp = 1;
      push_b(2, 1);
      tick(2);
      snap(1'b1, 0, 1, 0, 0, 0, "B wrap");
      tick(2);
      snap(1'b1, 2, 1, 1, 1, 0, "B trig after wrap");

      // 8-bit saturation: match at 0 every wrap, 300 times
      b_stop = 1; tick(1); b_stop = 0;
      b_clear = 1; b_cmp = 0; tick(1); b_clear = 0;
      snap(1'b1, 0, 0, 0, 0, 0, "B clear");
      for (int k = 1; k <= 300; k++) push_b(1, (k > 255) ? 8'd255 : 8'(k));
      b_start = 1; tick(1); b_start = 0;
      tick(1);
      tick(256 * 299);
      snap(1'b1, 1, 1, 1, 255, 0, "B saturated");
      b_stop = 1; tick(1); b_stop = 0;

      tick(2);
      chk("A trig queue drained", 32'(a_exp_q.size()), 32'd0);
      chk("B trig queue drained", 32'(b_exp_q.size()), 32'd0);
      chk("snapshot queue drained", 32'(snap_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
